// File: rtl/apb_wait_slave_mem.sv
// APB3/APB4 completer backed by a word-addressed register memory.
// Inserts WAIT_STATES PREADY-low ACCESS cycles per transfer; bad addresses answer with PSLVERR.
module apb_wait_slave_mem #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH   = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);
    localparam int IW = $clog2(MEM_DEPTH);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(4 * MEM_DEPTH);

    localparam logic [2:0] IDLE   = 3'b001;
    localparam logic [2:0] SETUP  = 3'b010;
    localparam logic [2:0] ACCESS = 3'b100;

    logic [2:0]              state;
    logic [3:0]              cnt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    wr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [NB-1:0]           strb_q;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    logic                    addr_err;
    logic [IW-1:0]           idx;
    logic                    start;
    logic                    capture;
    logic                    unused_pprot;

    assign unused_pprot = ^PPROT;

    assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q >= LIMIT);
    assign idx      = addr_q[2 +: IW];
    assign start    = PSEL && !PENABLE;
    // A new transfer is accepted from IDLE or straight out of a completing ACCESS.
    assign capture  = start && ((state == IDLE) || ((state == ACCESS) && PREADY));

    // Read data shows the pre-commit word, since writes land at the end of this cycle.
    assign PRDATA  = (PREADY && !wr_q && !addr_err) ? mem[idx] : '0;
    assign PSLVERR = PREADY && addr_err;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state   <= IDLE;
            cnt     <= '0;
            PREADY  <= 1'b0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= SETUP;
                end
                SETUP: begin
                    if (!PSEL) begin
                        state <= IDLE;
                    end else begin
                        state <= ACCESS;
                        if (cnt == 4'd0) PREADY <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (PREADY) begin
                        PREADY <= 1'b0;
                        if (wr_q && !addr_err) begin
                            for (int b = 0; b < NB; b++)
                                if (strb_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                        end
                        state <= start ? SETUP : IDLE;
                    end else if (!PSEL || !PENABLE) begin
                        // Abort: no response and nothing committed.
                        state <= IDLE;
                    end else begin
                        if (cnt == 4'd1) PREADY <= 1'b1;
                        if (cnt != 4'd0) cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (capture) begin
                addr_q  <= PADDR;
                wr_q    <= PWRITE;
                wdata_q <= PWDATA;
                strb_q  <= PSTRB;
                cnt     <= 4'(WAIT_STATES);
            end
        end
    end
endmodule

// File: tb/tb_apb_wait_slave_mem.sv
// Scoreboard bench for apb_wait_slave_mem: three instances with WAIT_STATES 0, 1 and 8.
module tb_apb_wait_slave_mem;
    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        preset;
    logic [2:0]  psel, penable;
    logic        pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata [3];
    logic [2:0]  pready, pslverr;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          ws [3]  = '{0, 1, 8};
    logic [31:0] mdl [3][16];
    exp_t        sb [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb_wait_slave_mem #(
            .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 1 : 8))
        ) u_dut (
            .PCLK    (clk),
            .PRESET  (preset),
            .PSEL    (psel[g]),
            .PENABLE (penable[g]),
            .PWRITE  (pwrite),
            .PADDR   (paddr),
            .PWDATA  (pwdata),
            .PSTRB   (pstrb),
            .PPROT   (pprot),
            .PRDATA  (prdata[g]),
            .PREADY  (pready[g]),
            .PSLVERR (pslverr[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        psel    = '0;
        penable = '0;
        tick();
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 16; j++) mdl[i][j] = '0;
    endtask

    // Starts SETUP at the current time; returns inside the PREADY cycle so a
    // caller may chain another transfer back-to-back or call idle().
    task automatic xfer(input int i, input logic we, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        output int cyc, output logic [31:0] got);
        exp_t        e;
        exp_t        p;
        logic        err;
        logic [3:0]  ix;
        logic        done;
        err    = (addr[1:0] != 2'b00) || (addr >= 32'd64);
        ix     = addr[5:2];
        e.err  = err;
        e.data = (!we && !err) ? mdl[i][ix] : 32'h0;
        sb.push_back(e);
        if (we && !err)
            for (int b = 0; b < 4; b++)
                if (strb[b]) mdl[i][ix][8*b +: 8] = data[8*b +: 8];
        psel[i] = 1'b1; penable[i] = 1'b0;
        pwrite = we; paddr = addr; pwdata = data; pstrb = strb;
        tick();
        cyc = 1;
        got = 32'hx;
        n_tests++;
        if (pready[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL setup_pready inst%0d: got %b want 0", i, pready[i]);
        end
        penable[i] = 1'b1;
        // Bus contents after SETUP must not matter.
        paddr = $urandom; pwdata = $urandom; pwrite = ~we; pstrb = ~strb;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            tick();
            cyc++;
            if (pready[i] === 1'b1) done = 1'b1;
        end
        n_tests++;
        p = sb.pop_front();
        if (!done) begin
            n_fail++;
            $display("FAIL timeout inst%0d addr %h: no PREADY within 20 cycles", i, addr);
        end else begin
            got = prdata[i];
            if ({pslverr[i], prdata[i]} !== p) begin
                n_fail++;
                $display("FAIL resp inst%0d addr %h: got err=%b data=%h want err=%b data=%h",
                         i, addr, pslverr[i], prdata[i], p.err, p.data);
            end
        end
    endtask

    task automatic test_reset();
        preset = 1'b1;
        tick(); tick();
        preset = 1'b0;
        clear_model();
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (pready[i] !== 1'b0 || pslverr[i] !== 1'b0 || prdata[i] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset inst%0d: got rdy=%b err=%b data=%h want 0 0 0",
                         i, pready[i], pslverr[i], prdata[i]);
            end
        end
    endtask

    task automatic test_basic();
        int cyc; logic [31:0] got;
        xfer(1, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, cyc, got);
        idle();
        xfer(1, 1'b0, 32'h04, 32'h0, 4'h0, cyc, got);
        n_tests++;
        if (cyc !== 3 || got !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL basic_read: got cyc=%0d data=%h want cyc=3 data=deadbeef", cyc, got);
        end
        idle();
    endtask

    task automatic test_strobe();
        int cyc; logic [31:0] got;
        xfer(1, 1'b1, 32'h08, 32'h11223344, 4'hF, cyc, got);
        idle();
        xfer(1, 1'b1, 32'h08, 32'hAABBCCDD, 4'b0101, cyc, got);
        idle();
        xfer(1, 1'b1, 32'h0C, 32'hCAFEF00D, 4'b0000, cyc, got);
        idle();
        xfer(1, 1'b0, 32'h08, 32'h0, 4'h0, cyc, got);
        n_tests++;
        if (got !== 32'h11BB33DD) begin
            n_fail++;
            $display("FAIL strobe_merge: got %h want 11bb33dd", got);
        end
        idle();
        xfer(1, 1'b0, 32'h0C, 32'h0, 4'h0, cyc, got);
        idle();
    endtask

    task automatic test_errors();
        int cyc; logic [31:0] got;
        xfer(1, 1'b1, 32'h00, 32'h5A5A5A5A, 4'hF, cyc, got);
        idle();
        xfer(1, 1'b0, 32'h40, 32'h0, 4'h0, cyc, got);
        idle();
        xfer(1, 1'b1, 32'h02, 32'hFFFFFFFF, 4'hF, cyc, got);
        idle();
        xfer(1, 1'b1, 32'h3C | 32'h100, 32'h12345678, 4'hF, cyc, got);
        idle();
        xfer(1, 1'b0, 32'h00, 32'h0, 4'h0, cyc, got);
        idle();
        xfer(1, 1'b0, 32'h3C, 32'h0, 4'h0, cyc, got);
        idle();
    endtask

    task automatic test_back_to_back();
        int cyc; logic [31:0] got;
        for (int i = 0; i < 3; i++) begin
            for (int t = 0; t < 4; t++) begin
                xfer(i, t < 2, 32'(t[0] ? 8'h10 : 8'h14), 32'hA000_0000 + 32'(i * 16 + t),
                     4'hF, cyc, got);
                n_tests++;
                if (cyc !== 2 + ws[i]) begin
                    n_fail++;
                    $display("FAIL b2b_len inst%0d xfer%0d: got %0d cycles want %0d",
                             i, t, cyc, 2 + ws[i]);
                end
            end
            idle();
            n_tests++;
            if (pready[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_tail inst%0d: got PREADY=%b want 0", i, pready[i]);
            end
        end
    endtask

    task automatic test_abort();
        int cyc; logic [31:0] got;
        logic seen;
        psel[1] = 1'b1; penable[1] = 1'b0;
        pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h0BADC0DE; pstrb = 4'hF;
        tick();
        penable[1] = 1'b1;
        tick();
        psel[1] = 1'b0; penable[1] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (pready[1] !== 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL abort_pready: got PREADY pulse want none");
        end
        xfer(1, 1'b0, 32'h04, 32'h0, 4'h0, cyc, got);
        idle();

        psel[1] = 1'b1; penable[1] = 1'b0;
        pwrite = 1'b1; paddr = 32'h18; pwdata = 32'h77777777; pstrb = 4'hF;
        tick();
        penable[1] = 1'b1;
        tick();
        preset = 1'b1;
        tick();
        preset = 1'b0;
        psel = '0; penable = '0;
        clear_model();
        n_tests++;
        if (pready[1] !== 1'b0 || pslverr[1] !== 1'b0 || prdata[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset: got rdy=%b err=%b data=%h want 0 0 0",
                     pready[1], pslverr[1], prdata[1]);
        end
        tick();
        for (int j = 0; j < 16; j++) begin
            xfer(1, 1'b0, 32'(j * 4), 32'h0, 4'h0, cyc, got);
        end
        idle();
    endtask

    task automatic test_penable_idle();
        int cyc; logic [31:0] got;
        logic seen;
        psel[1] = 1'b1; penable[1] = 1'b1;
        pwrite = 1'b1; paddr = 32'h20; pwdata = 32'hFEEDFACE; pstrb = 4'hF;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (pready[1] !== 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL penable_idle: got PREADY pulse want none");
        end
        xfer(1, 1'b0, 32'h20, 32'h0, 4'h0, cyc, got);
        idle();
        xfer(1, 1'b1, 32'h20, 32'h01020304, 4'hF, cyc, got);
        idle();
        xfer(1, 1'b0, 32'h20, 32'h0, 4'h0, cyc, got);
        n_tests++;
        if (got !== 32'h01020304) begin
            n_fail++;
            $display("FAIL penable_recover: got %h want 01020304", got);
        end
        idle();
    endtask

    initial begin
        preset = 1'b1; psel = '0; penable = '0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
        clear_model();
        test_reset();
        test_basic();
        test_strobe();
        test_errors();
        test_back_to_back();
        test_abort();
        test_penable_idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
